// File: rtl/controle_bcd_serial_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | controle_bcd_serial_pkg: shared FSM state type and sizing constants       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package controle_bcd_serial_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  localparam int LARGURA_BIN  = 16;
  localparam int N_DIGITOS    = 5;
  localparam int N_PASSOS     = 16;
  localparam int LARGURA_BCD  = 4 * N_DIGITOS;
  localparam int LARGURA_CONT = $clog2(N_PASSOS);

endpackage
`default_nettype wire

// File: rtl/controle_bcd_serial_passo_double_dabble.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | passo_double_dabble: one add-3-then-shift step on the BCD accumulator     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module passo_double_dabble
  import controle_bcd_serial_pkg::*;
(
  input  logic [LARGURA_BCD-1:0] bcd_in,
  input  logic                   bit_in,
  output logic [LARGURA_BCD-1:0] bcd_out
);

  logic [LARGURA_BCD-1:0] ajustado;

  for (genvar i = 0; i < N_DIGITOS; i++) begin : g_nibble
    assign ajustado[4*i +: 4] = (bcd_in[4*i +: 4] >= 4'd5) ? bcd_in[4*i +: 4] + 4'd3
                                                            : bcd_in[4*i +: 4];
  end

  assign bcd_out = {ajustado[LARGURA_BCD-2:0], bit_in};

endmodule
`default_nettype wire

// File: rtl/controle_bcd_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | controle_bcd_serial: two-requester round-robin serial binary-to-BCD unit  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module controle_bcd_serial
  import controle_bcd_serial_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pedido0,
  input  logic                   pedido1,
  input  logic [LARGURA_BIN-1:0] valor0,
  input  logic [LARGURA_BIN-1:0] valor1,
  output logic                   aceito0,
  output logic                   aceito1,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   dono,
  output logic [3:0]             dezenaDeMilhar,
  output logic [3:0]             milhar,
  output logic [3:0]             centena,
  output logic [3:0]             dezena,
  output logic [3:0]             unidade
);

  estado_t                 estado_q, estado_d;
  logic [LARGURA_BIN-1:0]  desloc_q, desloc_d;
  logic [LARGURA_BCD-1:0]  acc_q, acc_d;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;
  logic                    pendente_q, pendente_d;
  logic                    ultimo_q, ultimo_d;
  logic [LARGURA_BCD-1:0]  digitos_q, digitos_d;
  logic                    dono_q, dono_d;
  logic                    pronto_q, pronto_d;
  logic                    ocupado_q, ocupado_d;

  logic                    ocioso;
  logic                    conc0;
  logic                    conc1;
  logic [LARGURA_BCD-1:0]  passo_bcd;

  // Tie goes to whichever requester was not served last.
  assign ocioso = (estado_q == OCIOSO) && !reset;
  assign conc0  = ocioso && pedido0 && (!pedido1 || ultimo_q);
  assign conc1  = ocioso && pedido1 && (!pedido0 || !ultimo_q);

  passo_double_dabble u_passo (
    .bcd_in  (acc_q),
    .bit_in  (desloc_q[LARGURA_BIN-1]),
    .bcd_out (passo_bcd)
  );

  always_comb begin
    estado_d   = estado_q;
    desloc_d   = desloc_q;
    acc_d      = acc_q;
    cont_d     = cont_q;
    pendente_d = pendente_q;
    ultimo_d   = ultimo_q;
    digitos_d  = digitos_q;
    dono_d     = dono_q;
    pronto_d   = 1'b0;
    ocupado_d  = ocupado_q;
    case (estado_q)
      OCIOSO: begin
        if (conc0 || conc1) begin
          desloc_d   = conc1 ? valor1 : valor0;
          acc_d      = '0;
          cont_d     = '0;
          pendente_d = conc1;
          ultimo_d   = conc1;
          ocupado_d  = 1'b1;
          estado_d   = CONVERTE;
        end
      end
      CONVERTE: begin
        acc_d    = passo_bcd;
        desloc_d = {desloc_q[LARGURA_BIN-2:0], 1'b0};
        cont_d   = cont_q + 1'b1;
        // The last step's result goes straight to the visible digits.
        if (cont_q == LARGURA_CONT'(N_PASSOS - 1)) begin
          digitos_d = passo_bcd;
          dono_d    = pendente_q;
          pronto_d  = 1'b1;
          estado_d  = FIM;
        end
      end
      FIM: begin
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
      default: begin
        ocupado_d = 1'b0;
        estado_d  = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      desloc_q   <= '0;
      acc_q      <= '0;
      cont_q     <= '0;
      pendente_q <= 1'b0;
      ultimo_q   <= 1'b1;
      digitos_q  <= '0;
      dono_q     <= 1'b0;
      pronto_q   <= 1'b0;
      ocupado_q  <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      desloc_q   <= desloc_d;
      acc_q      <= acc_d;
      cont_q     <= cont_d;
      pendente_q <= pendente_d;
      ultimo_q   <= ultimo_d;
      digitos_q  <= digitos_d;
      dono_q     <= dono_d;
      pronto_q   <= pronto_d;
      ocupado_q  <= ocupado_d;
    end
  end

  assign aceito0        = conc0;
  assign aceito1        = conc1;
  assign ocupado        = ocupado_q;
  assign pronto         = pronto_q;
  assign dono           = dono_q;
  assign dezenaDeMilhar = digitos_q[19:16];
  assign milhar         = digitos_q[15:12];
  assign centena        = digitos_q[11:8];
  assign dezena         = digitos_q[7:4];
  assign unidade        = digitos_q[3:0];

endmodule
`default_nettype wire
